// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - opcode, ALU function, branch condition and MUL FSM definitions for ex_stage
package ex_pkg;

    localparam logic [3:0] OP_ALUR   = 4'b0000;
    localparam logic [3:0] OP_ALUI   = 4'b1000;
    localparam logic [3:0] OP_LW     = 4'b1001;
    localparam logic [3:0] OP_SW     = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [3:0] OP_JAL    = 4'b1011;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b0001;
    localparam logic [3:0] FN_MUL  = 4'b0011;
    localparam logic [3:0] FN_AND  = 4'b0100;
    localparam logic [3:0] FN_OR   = 4'b0101;
    localparam logic [3:0] FN_XOR  = 4'b0110;
    localparam logic [3:0] FN_NAND = 4'b1100;
    localparam logic [3:0] FN_NOR  = 4'b1101;
    localparam logic [3:0] FN_XNOR = 4'b1110;

    localparam logic [3:0] BR_F   = 4'b0000;
    localparam logic [3:0] BR_EQ  = 4'b0001;
    localparam logic [3:0] BR_LT  = 4'b0010;
    localparam logic [3:0] BR_LTE = 4'b0011;
    localparam logic [3:0] BR_T   = 4'b1000;
    localparam logic [3:0] BR_NE  = 4'b1001;
    localparam logic [3:0] BR_GTE = 4'b1010;
    localparam logic [3:0] BR_GT  = 4'b1011;

    localparam logic [1:0] SEL_REG2 = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;

    typedef enum logic {
        IDLE,
        BUSY
    } mul_state_e;

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU and signed branch-condition evaluator
module ex_alu
    import ex_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [3:0]       func,
    input  logic [DBITS-1:0] op_a,
    input  logic [DBITS-1:0] op_b,
    input  logic [DBITS-1:0] cmp_a,
    input  logic [DBITS-1:0] cmp_b,
    output logic [DBITS-1:0] result,
    output logic             cond_true
);

    logic signed [DBITS-1:0] sa;
    logic signed [DBITS-1:0] sb;

    always_comb begin
        result = '0;
        case (func)
            FN_ADD:  result = op_a + op_b;
            FN_SUB:  result = op_a - op_b;
            FN_MUL:  result = op_a * op_b;
            FN_AND:  result = op_a & op_b;
            FN_OR:   result = op_a | op_b;
            FN_XOR:  result = op_a ^ op_b;
            FN_NAND: result = ~(op_a & op_b);
            FN_NOR:  result = ~(op_a | op_b);
            FN_XNOR: result = ~(op_a ^ op_b);
            default: result = '0;
        endcase
    end

    always_comb begin
        sa = cmp_a;
        sb = cmp_b;
        cond_true = 1'b0;
        case (func)
            BR_F:    cond_true = 1'b0;
            BR_EQ:   cond_true = (sa == sb);
            BR_LT:   cond_true = (sa < sb);
            BR_LTE:  cond_true = (sa <= sb);
            BR_T:    cond_true = 1'b1;
            BR_NE:   cond_true = (sa != sb);
            BR_GTE:  cond_true = (sa >= sb);
            BR_GT:   cond_true = (sa > sb);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, multi-cycle MUL, branch resolution, EX/MEM register (optional EX_PERF_CNT_EN counters)
module ex_stage
    import ex_pkg::*;
#(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int MUL_LAT             = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DBITS-1:0]               DEC_pc,
    input  logic [DBITS-1:0]               DEC_brBaseOffset,
    input  logic [DBITS-1:0]               DEC_immval,
    input  logic [DBITS-1:0]               DEC_regData1,
    input  logic [DBITS-1:0]               DEC_regData2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rd,
    input  logic [3:0]                     DEC_op,
    input  logic [3:0]                     DEC_func,
    input  logic                           DEC_prediction,
    input  logic                           DEC_wrReg,
    input  logic                           DEC_wrMem,
    input  logic                           DEC_ME_mux_sel,
    input  logic [1:0]                     DEC_alu2MuxSel,
    output logic [DBITS-1:0]               EX_aluResult,
    output logic [DBITS-1:0]               EX_storeData,
    output logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    output logic                           EX_wrReg,
    output logic                           EX_wrMem,
    output logic                           EX_ME_mux_sel,
    output logic                           EX_stall,
    output logic                           EX_flush,
    output logic [DBITS-1:0]               EX_target,
    output logic                           EX_brResolved,
    output logic                           EX_brTaken,
    output logic [DBITS-1:0]               EX_brPc
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]                    EX_brCount,
    output logic [31:0]                    EX_mispredCount
`endif
);

    mul_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [DBITS-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [DBITS-1:0] alu_result_q, alu_result_d, store_data_q, store_data_d;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd_q, rd_d;
    logic wr_reg_q, wr_reg_d, wr_mem_q, wr_mem_d, me_sel_q, me_sel_d;

    logic [DBITS-1:0] pc4, op_b, alu_a, alu_b, alu_out, result;
    logic is_mul, is_br, is_jal, cond_true, stall;

    ex_alu #(.DBITS(DBITS)) u_alu (
        .func      (DEC_func),
        .op_a      (alu_a),
        .op_b      (alu_b),
        .cmp_a     (DEC_regData1),
        .cmp_b     (DEC_regData2),
        .result    (alu_out),
        .cond_true (cond_true)
    );

    always_comb begin
        pc4 = DEC_pc + DBITS'(4);
        case (DEC_alu2MuxSel)
            SEL_REG2: op_b = DEC_regData2;
            SEL_IMM:  op_b = DEC_immval;
            SEL_PC4:  op_b = pc4;
            default:  op_b = '0;
        endcase
        is_mul = ((DEC_op == OP_ALUR) || (DEC_op == OP_ALUI)) && (DEC_func == FN_MUL);
        is_br  = (DEC_op == OP_BRANCH);
        is_jal = (DEC_op == OP_JAL);
        // While BUSY the product comes from the operands latched when the MUL entered EX
        alu_a = (state_q == BUSY) ? mul_a_q : DEC_regData1;
        alu_b = (state_q == BUSY) ? mul_b_q : op_b;
        stall = (state_q == IDLE) ? is_mul : (cnt_q > 4'd1);

        case (DEC_op)
            OP_ALUR, OP_ALUI: result = alu_out;
            OP_LW, OP_SW:     result = DEC_regData1 + DEC_immval;
            OP_JAL:           result = pc4;
            default:          result = '0;
        endcase

        EX_stall      = stall;
        EX_brResolved = is_br || is_jal;
        EX_brTaken    = (is_br && cond_true) || is_jal;
        EX_brPc       = DEC_pc;
        EX_flush      = (is_br && (cond_true ^ DEC_prediction)) || (is_jal && !DEC_prediction);
        if (is_jal) begin
            EX_target = DEC_regData1 + (DEC_immval << 2);
        end else if (is_br && cond_true) begin
            EX_target = DEC_brBaseOffset;
        end else begin
            EX_target = pc4;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (state_q == IDLE) begin
            if (is_mul) begin
                state_d = BUSY;
                cnt_d   = 4'(MUL_LAT - 1);
                mul_a_d = DEC_regData1;
                mul_b_d = op_b;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
            end
        end

        alu_result_d = stall ? '0 : result;
        store_data_d = stall ? '0 : DEC_regData2;
        rd_d         = stall ? '0 : DEC_rd;
        wr_reg_d     = stall ? 1'b0 : DEC_wrReg;
        wr_mem_d     = stall ? 1'b0 : DEC_wrMem;
        me_sel_d     = stall ? 1'b0 : DEC_ME_mux_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            wr_reg_q     <= 1'b0;
            wr_mem_q     <= 1'b0;
            me_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            wr_reg_q     <= wr_reg_d;
            wr_mem_q     <= wr_mem_d;
            me_sel_q     <= me_sel_d;
        end
    end

    assign EX_aluResult  = alu_result_q;
    assign EX_storeData  = store_data_q;
    assign EX_rd         = rd_q;
    assign EX_wrReg      = wr_reg_q;
    assign EX_wrMem      = wr_mem_q;
    assign EX_ME_mux_sel = me_sel_q;

`ifdef EX_PERF_CNT_EN
    logic [31:0] br_count_q, br_count_d, mispred_count_q, mispred_count_d;

    always_comb begin
        br_count_d      = br_count_q + {31'd0, EX_brResolved};
        mispred_count_d = mispred_count_q + {31'd0, EX_flush};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign EX_brCount      = br_count_q;
    assign EX_mispredCount = mispred_count_q;
`endif

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the decode/execute pipeline register; consumes its DEC_* outputs.
- Performs ALU ops, a multi-cycle MUL, branch/JAL resolution against the fetch-time prediction, and drives redirect/flush to fetch and decode.
- Owns the EX/MEM pipeline register feeding the memory stage.

Parameters:
- DBITS, 32, datapath width
- REG_INDEX_BIT_WIDTH, 4, register index width
- MUL_LAT, 4, cycles MUL occupies EX (legal range 2..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- DEC_pc, DEC_brBaseOffset, DEC_immval, DEC_regData1, DEC_regData2  in  DBITS each  from decode/execute register; brBaseOffset is the precomputed branch target
- DEC_rd  in  REG_INDEX_BIT_WIDTH  destination register
- DEC_op, DEC_func  in  4 each  opcode, function code
- DEC_prediction, DEC_wrReg, DEC_wrMem, DEC_ME_mux_sel  in  1 each  fetch prediction, register-write enable, memory-write enable, writeback mux select
- DEC_alu2MuxSel  in  2  ALU operand-B select: 0 regData2, 1 immval, 2 DEC_pc+4, 3 reserved (selects 0)
- EX_aluResult, EX_storeData  out  DBITS each  registered ALU result, registered regData2
- EX_rd  out  REG_INDEX_BIT_WIDTH  registered destination
- EX_wrReg, EX_wrMem, EX_ME_mux_sel  out  1 each  registered controls
- EX_stall  out  1  combinational; holds fetch, decode and the decode/execute register
- EX_flush  out  1  combinational mispredict; squashes the fetch/decode and decode/execute registers
- EX_target  out  DBITS  combinational redirect PC
- EX_brResolved, EX_brTaken  out  1 each  combinational predictor update
- EX_brPc  out  DBITS  combinational predictor update

Behaviour:
- Reset: EX/MEM outputs all 0; FSM to IDLE; counter 0. Reset mid-MUL abandons the MUL with no writeback.
- ALU funcs, used for ALUR/ALUI: ADD 0000, SUB 0001, MUL 0011, AND 0100, OR 0101, XOR 0110, NAND 1100, NOR 1101, XNOR 1110; undefined funcs give 0. Operand A is regData1; B comes from alu2MuxSel.
- Arithmetic wraps modulo 2^DBITS; MUL keeps the low DBITS of the product.
- Opcodes: ALUR 0000, ALUI 1000, LW 1001 and SW 0101 (result = regData1+immval), BRANCH 0010, JAL 1011.
- Branch conditions, signed regData1 vs regData2: F 0000, EQ 0001, LT 0010, LTE 0011, T 1000, NE 1001, GTE 1010, GT 1011; others are not-taken.
- BRANCH: EX_brResolved=1; EX_brPc=DEC_pc; EX_brTaken=cond.
  - EX_flush = cond XOR DEC_prediction.
  - EX_target = cond ? DEC_brBaseOffset : DEC_pc+4.
  - Result written is 0.
- JAL: always taken; target = regData1 + (immval<<2); EX_flush = !DEC_prediction; EX_aluResult = DEC_pc+4.
- Non-branch ops: EX_flush, EX_brResolved and EX_brTaken are 0; EX_target = DEC_pc+4.
- Bubble = wrReg=0 and wrMem=0. A bubble still passes through; it never flushes unless its op is BRANCH/JAL.
- EX/MEM register latency is 1 cycle. It updates every cycle it is not stalled; during stall cycles it loads a bubble (controls 0, data 0).
- MUL FSM:
  - IDLE: on an ALUR/ALUI MUL, latch operands, set cnt=MUL_LAT-1, go BUSY, EX_stall=1.
  - BUSY: cnt decrements each cycle; EX_stall=1 while cnt>1.
  - When cnt==1: EX_stall=0, EX/MEM captures the product with DEC_rd and controls, then return to IDLE.
  - Total: MUL_LAT cycles in EX, MUL_LAT-1 bubbles to memory.
- Reset has priority over everything. EX_flush and EX_stall are never both 1, because MUL is not a branch.

Optional Feature:
- Macro EX_PERF_CNT_EN.
- Defined: adds outputs EX_brCount and EX_mispredCount, 32 bits each. They increment on EX_brResolved and EX_flush respectively, are cleared on reset, and wrap at 2^32.
- Undefined: these ports and counters are absent.

Decomposition:
- Package ex_pkg: opcode, ALU func and branch-cond localparams; ALU-select encodings; FSM state enum IDLE/BUSY.
- One sub-module, ex_alu: combinational ALU plus branch-condition evaluator. FSM, muxing and EX/MEM register stay in ex_stage.

Test Plan:
- ADD: regData1=5, alu2MuxSel=1 with immval=-3, wrReg=1, rd=2 -> next cycle EX_aluResult=2, EX_rd=2, EX_wrReg=1.
- BRANCH EQ: regData1=regData2=7, prediction=0, pc=0x100, brBaseOffset=0x140 -> EX_flush=1, EX_target=0x140, EX_brTaken=1. Repeat with prediction=1 -> EX_flush=0.
- BRANCH LT, signed: regData1=-4, regData2=1, prediction=1 -> cond true, no flush. Swap operands -> EX_flush=1, EX_target=pc+4.
- JAL: pc=0x200, regData1=0x1000, immval=4, prediction=0 -> EX_target=0x1010, EX_flush=1; next cycle EX_aluResult=0x204.
- MUL with MUL_LAT=4: 0xFFFF_FFFF*2 -> EX_stall high 3 cycles with bubbles to EX/MEM, then EX_aluResult=0xFFFF_FFFE. Assert reset in cycle 2 of a MUL -> outputs 0, no writeback.
- EX_PERF_CNT_EN defined: 3 branches including 1 mispredict -> EX_brCount=3, EX_mispredCount=1; reset -> both 0.
